// File: rtl/mac_rtl_pkg.sv
// Shared constants for the MAC operand path: packed-word field layout and
// the run-control state encoding.
package mac_rtl_pkg;

  localparam int A_LSB = 0;
  localparam int A_W   = 8;
  localparam int B_LSB = 8;
  localparam int B_W   = 8;
  localparam int C_LSB = 16;
  localparam int C_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/axis_fork_slot.sv
// One output leg of the operand fork: holds a pending flag for the current
// element until that leg's own handshake retires it.
module axis_fork_slot (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic load,
  input  logic tready,
  output logic tvalid,
  output logic clear_ok
);

  logic pend_q, pend_d;

  // A new load may coincide with retiring the previous element; the load wins.
  always_comb begin
    pend_d = pend_q;
    if (pend_q && tready) pend_d = 1'b0;
    if (load)             pend_d = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) pend_q <= 1'b0;
    else           pend_q <= pend_d;
  end

  assign tvalid   = pend_q;
  assign clear_ok = ~pend_q | tready;

endmodule

// File: rtl/mac_operand_src.sv
// Splits packed {c,b,a} input words onto three independent operand streams,
// framed by ap_ctrl start/done with tlast on the final element.
//   state   | meaning
//   ST_IDLE | waiting for a start pulse; ap_idle/ap_ready high
//   ST_BUSY | accepting and forking num_latched elements
module mac_operand_src
  import mac_rtl_pkg::*;
#(
  parameter int C_S_AXIS_IN_TDATA_WIDTH = 1024,
  parameter int C_M_AXIS_A_TDATA_WIDTH  = 1024,
  parameter int C_M_AXIS_B_TDATA_WIDTH  = 1024,
  parameter int C_M_AXIS_C_TDATA_WIDTH  = 1024
) (
  input  logic                                  ap_clk,
  input  logic                                  ap_rst_n,
  input  logic                                  s_axis_in_tvalid,
  output logic                                  s_axis_in_tready,
  input  logic [C_S_AXIS_IN_TDATA_WIDTH-1:0]    s_axis_in_tdata,
  input  logic [C_S_AXIS_IN_TDATA_WIDTH/8-1:0]  s_axis_in_tkeep,
  input  logic                                  s_axis_in_tlast,
  output logic                                  m_axis_a_tvalid,
  input  logic                                  m_axis_a_tready,
  output logic [C_M_AXIS_A_TDATA_WIDTH-1:0]     m_axis_a_tdata,
  output logic [C_M_AXIS_A_TDATA_WIDTH/8-1:0]   m_axis_a_tkeep,
  output logic                                  m_axis_a_tlast,
  output logic                                  m_axis_b_tvalid,
  input  logic                                  m_axis_b_tready,
  output logic [C_M_AXIS_B_TDATA_WIDTH-1:0]     m_axis_b_tdata,
  output logic [C_M_AXIS_B_TDATA_WIDTH/8-1:0]   m_axis_b_tkeep,
  output logic                                  m_axis_b_tlast,
  output logic                                  m_axis_c_tvalid,
  input  logic                                  m_axis_c_tready,
  output logic [C_M_AXIS_C_TDATA_WIDTH-1:0]     m_axis_c_tdata,
  output logic [C_M_AXIS_C_TDATA_WIDTH/8-1:0]   m_axis_c_tkeep,
  output logic                                  m_axis_c_tlast,
  input  logic [31:0]                           num_elems,
  input  logic                                  ap_start,
  output logic                                  ap_idle,
  output logic                                  ap_ready,
  output logic                                  ap_done
);

  state_e      state_q, state_d;
  logic        ap_start_d_q;
  logic [31:0] num_latched_q, num_latched_d;
  logic [31:0] in_cnt_q, in_cnt_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic        ap_done_q, ap_done_d;

  logic start_pulse, in_hs, drain_ok, any_pend;
  logic ok_a, ok_b, ok_c;
  logic unused_in;

  assign unused_in = ^{s_axis_in_tkeep, s_axis_in_tlast,
                       s_axis_in_tdata[C_S_AXIS_IN_TDATA_WIDTH-1:32]};

  assign start_pulse      = ap_start & ~ap_start_d_q;
  assign drain_ok         = ok_a & ok_b & ok_c;
  assign any_pend         = m_axis_a_tvalid | m_axis_b_tvalid | m_axis_c_tvalid;
  assign s_axis_in_tready = (state_q == ST_BUSY) & drain_ok & (in_cnt_q < num_latched_q);
  assign in_hs            = s_axis_in_tvalid & s_axis_in_tready;

  always_comb begin
    state_d       = state_q;
    num_latched_d = num_latched_q;
    in_cnt_d      = in_cnt_q;
    word_d        = word_q;
    last_d        = last_q;
    ap_done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          if (num_elems != 32'd0) begin
            state_d       = ST_BUSY;
            num_latched_d = num_elems;
            in_cnt_d      = 32'd0;
            last_d        = 1'b0;
          end else begin
            ap_done_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (in_hs) begin
          word_d   = s_axis_in_tdata[31:0];
          last_d   = (in_cnt_q == num_latched_q - 32'd1);
          in_cnt_d = in_cnt_q + 32'd1;
        end
        // Final element retires when its last outstanding leg handshakes.
        if (last_q && any_pend && drain_ok) begin
          ap_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= ST_IDLE;
      ap_start_d_q  <= 1'b0;
      num_latched_q <= 32'd0;
      in_cnt_q      <= 32'd0;
      word_q        <= 32'd0;
      last_q        <= 1'b0;
      ap_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ap_start_d_q  <= ap_start;
      num_latched_q <= num_latched_d;
      in_cnt_q      <= in_cnt_d;
      word_q        <= word_d;
      last_q        <= last_d;
      ap_done_q     <= ap_done_d;
    end
  end

  axis_fork_slot u_slot_a (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .load     (in_hs),
    .tready   (m_axis_a_tready),
    .tvalid   (m_axis_a_tvalid),
    .clear_ok (ok_a)
  );

  axis_fork_slot u_slot_b (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .load     (in_hs),
    .tready   (m_axis_b_tready),
    .tvalid   (m_axis_b_tvalid),
    .clear_ok (ok_b)
  );

  axis_fork_slot u_slot_c (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .load     (in_hs),
    .tready   (m_axis_c_tready),
    .tvalid   (m_axis_c_tvalid),
    .clear_ok (ok_c)
  );

  assign m_axis_a_tdata = C_M_AXIS_A_TDATA_WIDTH'(word_q[A_LSB +: A_W]);
  assign m_axis_b_tdata = C_M_AXIS_B_TDATA_WIDTH'(word_q[B_LSB +: B_W]);
  assign m_axis_c_tdata = C_M_AXIS_C_TDATA_WIDTH'(word_q[C_LSB +: C_W]);
  assign m_axis_a_tkeep = (C_M_AXIS_A_TDATA_WIDTH/8)'(1);
  assign m_axis_b_tkeep = (C_M_AXIS_B_TDATA_WIDTH/8)'(1);
  assign m_axis_c_tkeep = (C_M_AXIS_C_TDATA_WIDTH/8)'(3);
  assign m_axis_a_tlast = last_q;
  assign m_axis_b_tlast = last_q;
  assign m_axis_c_tlast = last_q;

  assign ap_idle  = (state_q == ST_IDLE);
  assign ap_ready = (state_q == ST_IDLE);
  assign ap_done  = ap_done_q;

endmodule

// File: doc/mac_operand_src.md
# mac_operand_src

Source-side kernel that feeds the MAC datapath's three operand streams. It accepts one packed AXI4-Stream word per element, carrying {c[15:0], b[7:0], a[7:0]}, and forks it onto three independent AXI4-Stream masters: a, b and c. It frames each run with ap_ctrl start/done and asserts tlast on the final element of every channel. It sits between the host-fed input stream and the MAC kernel's s_axis_a/b/c ports.

## Interface
- C_S_AXIS_IN_TDATA_WIDTH, 1024, input stream width; only bits [31:0] are used.
- C_M_AXIS_A_TDATA_WIDTH, 1024, width of a-channel data.
- C_M_AXIS_B_TDATA_WIDTH, 1024, width of b-channel data.
- C_M_AXIS_C_TDATA_WIDTH, 1024, width of c-channel data.
- ap_clk  in  1  clock. All logic is on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- s_axis_in_tvalid / s_axis_in_tready  in/out  1  input handshake.
- s_axis_in_tdata  in  C_S_AXIS_IN_TDATA_WIDTH  packed operands: a = [7:0], b = [15:8], c = [31:16].
- s_axis_in_tkeep, s_axis_in_tlast  in  W/8, 1  ignored.
- m_axis_{a,b,c}_tvalid  out  1  per-channel valid.
- m_axis_{a,b,c}_tready  in  1  per-channel ready.
- m_axis_{a,b,c}_tdata  out  channel width  operand, zero-extended.
- m_axis_{a,b,c}_tkeep  out  W/8  fixed: a = 0x1, b = 0x1, c = 0x3.
- m_axis_{a,b,c}_tlast  out  1  high on element num_elems-1.
- num_elems  in  32  element count; sampled on the start pulse.
- ap_start  in  1  level input. Its rising edge starts a run.
- ap_idle, ap_ready  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse at run completion.

## Operation
- Start pulse = ap_start & ~ap_start_d, where ap_start_d is ap_start registered.
- FSM states: IDLE and BUSY.
  - IDLE→BUSY: start pulse with num_elems ≠ 0. num_elems is latched; in_cnt clears to 0.
  - IDLE, start pulse with num_elems = 0: ap_done pulses the next cycle; state stays IDLE.
  - BUSY→IDLE: the cycle the final element's last pending flag clears.
  - Start pulses in BUSY are ignored.
- Holding stage: one word register plus pend_a, pend_b, pend_c and a last_q bit.
- m_axis_x_tvalid = pend_x. tdata and tlast come from the holding register, so they are stable while valid is high.
- pend_x clears on its own handshake. The channels drain independently, in any order and at any skew.
- drain_ok = no pend bit set, or every set pend bit is handshaking this cycle.
- s_axis_in_tready = BUSY & drain_ok & (in_cnt < num_latched).
- Input handshake:
  - loads the word;
  - sets all three pend bits;
  - sets last_q = (in_cnt == num_latched−1);
  - increments in_cnt.
- Input tlast is ignored. Framing comes only from num_elems.
- Completion: the last pend bit of an element with last_q = 1 clears. ap_done is registered high for the next cycle, and state returns to IDLE.
- Counters are 32-bit. num_elems = 0xFFFFFFFF is legal; in_cnt never wraps because acceptance stops at num_latched.
- Reset, including mid-run:
  - state = IDLE;
  - all pend bits, in_cnt, last_q, ap_done and ap_start_d = 0;
  - the word register = 0;
  - all tvalid = 0; s_axis_in_tready = 0; ap_idle = ap_ready = 1.
  - Partially sent elements are discarded.

## Timing
- Latency: input handshake in cycle N → all three tvalid high in cycle N+1.
- Throughput: 1 element/cycle when all three readys are held high. A new word is accepted in the same cycle the previous one completes.
- Back-pressure on any channel stalls input acceptance. Already-issued channels do not re-send; a channel accepts each element exactly once.
- ap_done: asserted exactly one cycle, in the cycle after the final channel handshake; ap_idle rises in that same cycle.
- Start pulse in cycle N → BUSY from N+1. s_axis_in_tready can first be high in N+1.

## Structure
- Shared package mac_rtl_pkg holds:
  - field constants: A_LSB = 0, A_W = 8, B_LSB = 8, B_W = 8, C_LSB = 16, C_W = 16;
  - the IDLE/BUSY state encoding.
- One sub-module, axis_fork_slot, instantiated three times. Each instance holds one pend bit and produces tvalid, plus a "done or handshaking" term for drain_ok.

## Test plan
- num_elems = 4, all readys high, inputs 0x0003_0201, 0x0006_0504, 0x0009_0807, 0x000C_0B0A → a = 01, 04, 07, 0A; b = 02, 05, 08, 0B; c = 0003, 0006, 0009, 000C; back-to-back with tlast only on the 4th; ap_done 1 cycle after the 4th handshake.
- num_elems = 3, b-ready low for 5 cycles on element 1 → a and c take element 1 once each; input tready low until b takes it; no duplicates or drops; ordering preserved on all channels.
- num_elems = 0 start pulse → ap_done pulses for 1 cycle; no tvalid; s_axis_in_tready stays 0.
- num_elems = 2, input offers 3 words → only 2 are accepted; tready drops after the 2nd; the 3rd is not consumed.
- ap_rst_n asserted mid-run with pend_a set → all tvalid drop immediately; ap_idle = 1; a fresh run of num_elems = 1 then completes normally.
- Random per-channel ready toggling, num_elems = 1000 → scoreboard matches each channel's sequence exactly and exactly one tlast per channel.
